// File: rtl/add_round_key_stage.sv
// add_round_key_stage: registered AES-128 AddRoundKey stage with an on-the-fly key schedule.
// Bit order: spec bit 0 (MSB of byte 0) is vector bit 127; column c occupies [127-32*c -: 32].
// Optional macro ARK_ROUND_KEY_OUT_EN adds a registered round_key_out debug port.
module add_round_key_stage #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [3:0]   round_out,
    output logic         key_valid
`ifdef ARK_ROUND_KEY_OUT_EN
    ,
    output logic [127:0] round_key_out
`endif
);

    localparam int unsigned BW = 128;
    localparam int unsigned RW = 4;

    localparam logic [0:0] NO_KEY = 1'b0;
    localparam logic [0:0] RUN    = 1'b1;

    logic [0:0]    fsm_q, fsm_d;
    logic [BW-1:0] cipher_key_q, cipher_key_d;
    logic [BW-1:0] round_key_q, round_key_d;
    logic [RW-1:0] round_q, round_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          key_valid_q, key_valid_d;
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] state_out_q, state_out_d;
    logic [RW-1:0] round_out_q, round_out_d;
`ifdef ARK_ROUND_KEY_OUT_EN
    logic [BW-1:0] round_key_out_q, round_key_out_d;
`endif

    logic          in_ready_c;
    logic          xfer_c;
    logic [BW-1:0] round_key_next_c;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = gf_mul(x, x);
        r = p;
        for (int unsigned i = 0; i < 6; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [BW-1:0] next_round_key(input logic [BW-1:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign state_out = state_out_q;
    assign round_out = round_out_q;
    assign key_valid = key_valid_q;
`ifdef ARK_ROUND_KEY_OUT_EN
    assign round_key_out = round_key_out_q;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= NO_KEY;
        else        fsm_q <= fsm_d;
    end

    // Next-state, handshake, key schedule and output datapath.
    always_comb begin
        fsm_d        = fsm_q;
        cipher_key_d = cipher_key_q;
        round_key_d  = round_key_q;
        round_d      = round_q;
        rcon_d       = rcon_q;
        key_valid_d  = key_valid_q;
        out_valid_d  = out_valid_q;
        state_out_d  = state_out_q;
        round_out_d  = round_out_q;
`ifdef ARK_ROUND_KEY_OUT_EN
        round_key_out_d = round_key_out_q;
`endif

        round_key_next_c = next_round_key(round_key_q, rcon_q);
        in_ready_c = (fsm_q == RUN) && !key_load && (!out_valid_q || out_ready);
        xfer_c     = in_valid && in_ready_c;

        if (key_load) begin
            fsm_d        = RUN;
            cipher_key_d = key_in;
            round_key_d  = key_in;
            round_d      = '0;
            rcon_d       = 8'h01;
            key_valid_d  = 1'b1;
        end else if (xfer_c) begin
            if (round_q < RW'(NR)) begin
                round_key_d = round_key_next_c;
                round_d     = round_q + RW'(1);
                rcon_d      = xtime(rcon_q);
            end else begin
                round_key_d = cipher_key_q;
                round_d     = '0;
                rcon_d      = 8'h01;
            end
        end

        if (xfer_c) begin
            out_valid_d = 1'b1;
            state_out_d = state_in ^ round_key_q;
            round_out_d = round_q;
`ifdef ARK_ROUND_KEY_OUT_EN
            round_key_out_d = round_key_q;
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath and key schedule registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipher_key_q <= '0;
            round_key_q  <= '0;
            round_q      <= '0;
            rcon_q       <= 8'h01;
            key_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            state_out_q  <= '0;
            round_out_q  <= '0;
`ifdef ARK_ROUND_KEY_OUT_EN
            round_key_out_q <= '0;
`endif
        end else begin
            cipher_key_q <= cipher_key_d;
            round_key_q  <= round_key_d;
            round_q      <= round_d;
            rcon_q       <= rcon_d;
            key_valid_q  <= key_valid_d;
            out_valid_q  <= out_valid_d;
            state_out_q  <= state_out_d;
            round_out_q  <= round_out_d;
`ifdef ARK_ROUND_KEY_OUT_EN
            round_key_out_q <= round_key_out_d;
`endif
        end
    end

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb_add_round_key_stage: scoreboard bench for add_round_key_stage against a FIPS-197 key expansion model.
module tb_add_round_key_stage;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    typedef struct packed {
        logic [127:0] state;
        logic [3:0]   round;
        logic [127:0] rk;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_load = 1'b0;
    logic [127:0] key_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] state_out;
    logic [3:0]   round_out;
    logic         key_valid;
`ifdef ARK_ROUND_KEY_OUT_EN
    logic [127:0] round_key_out;
`endif

    add_round_key_stage #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .round_out (round_out),
        .key_valid (key_valid)
`ifdef ARK_ROUND_KEY_OUT_EN
        ,
        .round_key_out (round_key_out)
`endif
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail = 0;
    int           n_push = 0;
    exp_t         exp_q[$];
    logic [127:0] pop_log[$];
    logic [3:0]   pop_rnd[$];
    logic [7:0]   sb [256];
    logic [127:0] rk [11];
    int           m_round = 0;
    logic         xfer_prev = 1'b0;
    logic         hold_prev = 1'b0;
    logic [127:0] held_state = '0;
    logic [3:0]   held_round = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Carry-less multiply then reduce modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++)
                sb[x][i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                           ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        end
    endtask

    task automatic model_load(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0)
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {RCON[i / 4 - 1], 24'h0};
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        m_round = 0;
    endtask

    // One clock: drive at negedge, sample 1 time unit later, then wait for the active edge.
    task automatic step(input logic kl, input logic [127:0] k, input logic iv,
                        input logic [127:0] st, input logic ordy, output logic rdy);
        exp_t e;
        @(negedge clk);
        key_load = kl; key_in = k; in_valid = iv; state_in = st; out_ready = ordy;
        #1;
        rdy = in_ready;
        if (xfer_prev) check("latency_valid", 128'(out_valid), 128'(1'b1));
        if (hold_prev && out_valid) begin
            check("hold_state", state_out, held_state);
            check("hold_round", 128'(round_out), 128'(held_round));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 128'(1'b1), 128'(1'b0));
            end else begin
                e = exp_q.pop_front();
                check("state_out", state_out, e.state);
                check("round_out", 128'(round_out), 128'(e.round));
`ifdef ARK_ROUND_KEY_OUT_EN
                check("round_key_out", round_key_out, e.rk);
`endif
                pop_log.push_back(state_out);
                pop_rnd.push_back(round_out);
            end
        end
        if (kl) check("in_ready_key_load", 128'(in_ready), 128'(1'b0));
        xfer_prev = in_valid && in_ready;
        if (in_valid && in_ready) begin
            e.state = state_in ^ rk[m_round];
            e.round = 4'(m_round);
            e.rk    = rk[m_round];
            exp_q.push_back(e);
            n_push++;
            m_round = (m_round == 10) ? 0 : m_round + 1;
        end
        if (kl) model_load(k);
        hold_prev  = out_valid && !out_ready;
        held_state = state_out;
        held_round = round_out;
        @(posedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
        check({tag, "_state_out"}, state_out, 128'(0));
        check({tag, "_round_out"}, 128'(round_out), 128'(0));
        check({tag, "_key_valid"}, 128'(key_valid), 128'(1'b0));
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1'b0));
`ifdef ARK_ROUND_KEY_OUT_EN
        check({tag, "_round_key_out"}, round_key_out, 128'(0));
`endif
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic rdy;
        logic [127:0] k2;
        int cyc;
        build_sbox();

        // Reset and idle before any key.
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        #1 check_reset("reset");
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 check("in_ready_no_key", 128'(in_ready), 128'(1'b0));
        end
        in_valid = 1'b0;

        // Known-answer schedule: 12 back-to-back zero blocks.
        step(1'b1, FIPS_KEY, 1'b0, '0, 1'b1, rdy);
        @(negedge clk);
        #1 check("key_valid_after_load", 128'(key_valid), 128'(1'b1));
        pop_log.delete();
        pop_rnd.delete();
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, '0, 1'b1, rdy);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b1, rdy);
        check("kat_count", 128'(pop_log.size()), 128'(12));
        if (pop_log.size() == 12) begin
            check("kat_round0", pop_log[0], FIPS_KEY);
            check("kat_round1", pop_log[1], FIPS_RK1);
            check("kat_round10", pop_log[10], FIPS_RK10);
            check("kat_round10_idx", 128'(pop_rnd[10]), 128'(10));
            check("kat_wrap_idx", 128'(pop_rnd[11]), 128'(0));
        end

        // Backpressure: output stalled for 5 cycles while input keeps offering.
        step(1'b0, '0, 1'b1, rnd128(), 1'b0, rdy);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, rnd128(), 1'b0, rdy);
            check("in_ready_backpressure", 128'(rdy), 128'(1'b0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, rnd128(), 1'b1, rdy);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b1, rdy);

        // Reload mid-sequence at round 4 with a block offered in the load cycle.
        k2 = rnd128();
        step(1'b1, k2, 1'b0, '0, 1'b1, rdy);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, rnd128(), 1'b1, rdy);
        step(1'b1, rnd128(), 1'b1, rnd128(), 1'b1, rdy);
        pop_rnd.delete();
        step(1'b0, '0, 1'b1, rnd128(), 1'b1, rdy);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, '0, 1'b1, rdy);
        if (pop_rnd.size() > 0) check("reload_round0", 128'(pop_rnd[pop_rnd.size() - 1]), 128'(0));
        else check("reload_round0_seen", 128'(0), 128'(1));

        // Random traffic: 1000 blocks, random handshakes and occasional key reloads.
        n_push = 0;
        cyc = 0;
        while (n_push < 1000 && cyc < 20000) begin
            step($urandom_range(0, 39) == 0, rnd128(), $urandom_range(0, 2) != 0,
                 rnd128(), $urandom_range(0, 3) != 0, rdy);
            cyc++;
        end
        check("random_pushed", 128'(n_push >= 1000), 128'(1'b1));
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b0, '0, 1'b1, rdy);
        check("drain_empty", 128'(exp_q.size()), 128'(0));

        // Asynchronous reset mid-run with a stalled output.
        step(1'b0, '0, 1'b1, rnd128(), 1'b0, rdy);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        #1 check_reset("midrun_reset");
        exp_q.delete();
        xfer_prev = 1'b0;
        hold_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("in_ready_after_reset", 128'(in_ready), 128'(1'b0));
        @(negedge clk);
        #1 check("out_valid_after_reset", 128'(out_valid), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
